// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the programmable clock-divider scheduler.
package clk_div_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    // High time of a divide-by-n period; done in 32 bits so n = 2^CNT_W-1 cannot overflow.
    function automatic int unsigned high_time(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Ratio reconfiguration channel: cfg_div is taken when cfg_valid && cfg_ready on a rising clk edge.
interface clk_div_sched_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_core.sv
// Period counter with wrap detection and registered-state output decode.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary,
    output logic             div_out,
    output logic             tick_rise,
    output logic             tick_fall
);

    logic [CNT_W:0] high;

    assign high     = (CNT_W+1)'(high_time(32'(div)));
    assign boundary = run && (cnt == div - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || restart || boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // run comes from registered state, so every output here is a pure function of flops.
    assign div_out   = run && ({1'b0, cnt} < high);
    assign tick_rise = run && (cnt == '0);
    assign tick_fall = run && ({1'b0, cnt} == high);

endmodule

// File: rtl/clk_div_sched.sv
// Run/stop and ratio-switch FSM around clk_div_core; ratio changes only land on period boundaries.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    clk_div_sched_if.slave         cfg,
    output logic                   div_out,
    output logic                   tick_rise,
    output logic                   tick_fall,
    output logic                   busy,
    output logic [CNT_W-1:0]       cur_div,
    output logic [1:0]             state
);

    localparam logic [1:0] ST_STOP   = STOP;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_SWITCH = SWITCH;

    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] cnt;
    logic             boundary;
    logic             hs;
    logic             legal;
    logic             err_q;

    assign cfg.cfg_ready = (state != ST_SWITCH);
    assign cfg.cfg_err   = err_q;
    assign hs            = cfg.cfg_valid && cfg.cfg_ready;
    assign legal         = (cfg.cfg_div >= CNT_W'(MIN_DIV));
    assign busy          = (state != ST_STOP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A legal request wins over a stop so the new ratio is still applied first.
                if (hs && legal)          state_nxt = ST_SWITCH;
                else if (boundary && !en) state_nxt = ST_STOP;
            end
            ST_SWITCH: begin
                if (boundary) state_nxt = en ? ST_RUN : ST_STOP;
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_STOP;
            cur_div <= CNT_W'(DEF_DIV);
            pend    <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= hs && !legal;
            if (state == ST_RUN && hs && legal) begin
                pend <= cfg.cfg_div;
            end
            if (state == ST_STOP && hs && legal) begin
                cur_div <= cfg.cfg_div;
            end else if (state == ST_SWITCH && boundary) begin
                cur_div <= pend;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .run       (busy),
        .restart   (state == ST_SWITCH && boundary),
        .div       (cur_div),
        .cnt       (cnt),
        .boundary  (boundary),
        .div_out   (div_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

endmodule
